// File: rtl/sha3_pkg.sv
// Shared Keccak-f[1600] types, sizes and lane helpers for the SHA-3 permutation stages.
package sha3_pkg;

    localparam int LANE_W   = 64;
    localparam int NLANE    = 25;
    localparam int NCOL     = 5;
    localparam int STATE_W  = LANE_W * NLANE;
    localparam int PARITY_W = LANE_W * NCOL;

    typedef logic [LANE_W-1:0] lane_t;

    // Flat lane position of A[x][y] inside the packed state.
    function automatic int lane_idx(input int x, input int y);
        return 5 * y + x;
    endfunction

    // Rotate left by n bits; n is reduced modulo the lane width so rho offsets can be passed directly.
    function automatic lane_t rotl(input lane_t v, input int n);
        int s;
        s = n % LANE_W;
        if (s < 0) begin
            s = s + LANE_W;
        end
        return (v << s) | (v >> (LANE_W - s));
    endfunction

endpackage

// File: rtl/sha3_col_parity.sv
// Column parity of a Keccak state: C[x] = XOR of the five lanes in column x, purely combinational.
module sha3_col_parity
    import sha3_pkg::*;
(
    input  logic [STATE_W-1:0]  state,
    output logic [PARITY_W-1:0] parity
);

    genvar gi;
    generate
        for (gi = 0; gi < NCOL; gi++) begin : g_col
            assign parity[gi*LANE_W +: LANE_W] =
                state[lane_idx(gi, 0)*LANE_W +: LANE_W] ^
                state[lane_idx(gi, 1)*LANE_W +: LANE_W] ^
                state[lane_idx(gi, 2)*LANE_W +: LANE_W] ^
                state[lane_idx(gi, 3)*LANE_W +: LANE_W] ^
                state[lane_idx(gi, 4)*LANE_W +: LANE_W];
        end
    endgenerate

endmodule

// File: rtl/sha3_theta_step.sv
// Keccak-f[1600] theta step with registered outputs and a one-cycle valid pipeline.
// Define SHA3_THETA_PARITY_EN to expose the registered column parities on col_parity.
module sha3_theta_step
    import sha3_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pushin,
    input  logic [STATE_W-1:0]   state_in,
    output logic [STATE_W-1:0]   state_out,
    output logic                 pushout
`ifdef SHA3_THETA_PARITY_EN
    ,
    output logic [PARITY_W-1:0]  col_parity
`endif
);

    logic [PARITY_W-1:0] parity_w;
    logic [STATE_W-1:0]  theta_w;
    lane_t               c_lane [NCOL];
    lane_t               d_lane [NCOL];

    logic [STATE_W-1:0]  state_q, state_d;
    logic                pushout_q, pushout_d;

    sha3_col_parity u_col_parity (
        .state  (state_in),
        .parity (parity_w)
    );

    genvar gi, gy;
    generate
        for (gi = 0; gi < NCOL; gi++) begin : g_d
            assign c_lane[gi] = parity_w[gi*LANE_W +: LANE_W];
            // Neighbour columns wrap: x-1 of column 0 is column 4, x+1 of column 4 is column 0.
            assign d_lane[gi] = c_lane[(gi + NCOL - 1) % NCOL] ^ rotl(c_lane[(gi + 1) % NCOL], 1);
            for (gy = 0; gy < NCOL; gy++) begin : g_lane
                assign theta_w[lane_idx(gi, gy)*LANE_W +: LANE_W] =
                    state_in[lane_idx(gi, gy)*LANE_W +: LANE_W] ^ d_lane[gi];
            end
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        pushout_d = 1'b0;
        if (pushin) begin
            state_d   = theta_w;
            pushout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= '0;
            pushout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pushout_q <= pushout_d;
        end
    end

    assign state_out = state_q;
    assign pushout   = pushout_q;

`ifdef SHA3_THETA_PARITY_EN
    logic [PARITY_W-1:0] parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (pushin) begin
            parity_d = parity_w;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= '0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign col_parity = parity_q;
`endif

endmodule

// File: tb/tb_sha3_theta_step.sv
// Scoreboard bench for sha3_theta_step: bit-level reference model, decoupled stimulus and monitor.
// Parity checks are compiled in when SHA3_THETA_PARITY_EN is defined.
module tb_sha3_theta_step;

    logic          clk;
    logic          reset;
    logic          pushin;
    logic [1599:0] state_in;
    logic [1599:0] state_out;
    logic          pushout;
`ifdef SHA3_THETA_PARITY_EN
    logic [319:0]  col_parity;
`endif

    typedef struct {
        logic [1599:0] st;
        logic [319:0]  par;
    } exp_t;

    exp_t          exp_q[$];
    logic [1599:0] hold_st;
    logic [319:0]  hold_par;
    int            total;
    int            bad;
    int            txn;

    sha3_theta_step dut (
        .clk       (clk),
        .reset     (reset),
        .pushin    (pushin),
        .state_in  (state_in),
        .state_out (state_out),
        .pushout   (pushout)
`ifdef SHA3_THETA_PARITY_EN
        ,
        .col_parity(col_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference theta from the textbook definition, bit by bit over A[x][y][z].
    function automatic exp_t theta_model(input logic [1599:0] s);
        exp_t        r;
        logic [63:0] a [5][5];
        logic        c [5][64];
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                a[x][y] = s[64*(5*y+x) +: 64];
        for (int x = 0; x < 5; x++)
            for (int z = 0; z < 64; z++) begin
                c[x][z] = 1'b0;
                for (int y = 0; y < 5; y++) c[x][z] = c[x][z] ^ a[x][y][z];
                r.par[64*x+z] = c[x][z];
            end
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++)
                    r.st[64*(5*y+x)+z] = a[x][y][z] ^ c[(x+4)%5][z] ^ c[(x+1)%5][(z+63)%64];
        return r;
    endfunction

    function automatic logic [1599:0] rand_state();
        logic [1599:0] s;
        for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    // One clock cycle of stimulus; the expected result is queued at the capturing edge.
    task automatic drive_cycle(input logic pin, input logic [1599:0] st, input exp_t e);
        pushin   = pin;
        state_in = st;
        @(posedge clk);
        if (pin) exp_q.push_back(e);
        #1;
    endtask

    task automatic push_model(input logic [1599:0] st);
        drive_cycle(1'b1, st, theta_model(st));
    endtask

    task automatic idle_cycle();
        exp_t e;
        e.st  = '0;
        e.par = '0;
        drive_cycle(1'b0, rand_state(), e);
    endtask

    task automatic check(input string name, input logic [1599:0] act, input logic [1599:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h... required %h... (low 128 bits)", name, act[127:0], req[127:0]);
        end
    endtask

    // Monitor: every cycle out of reset, pushout must match the scoreboard and data must match or hold.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("pushout", {1599'b0, pushout}, {1599'b0, (exp_q.size() != 0)});
                if (pushout && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("state_out", state_out, e.st);
`ifdef SHA3_THETA_PARITY_EN
                    check("col_parity", {1280'b0, col_parity}, {1280'b0, e.par});
`endif
                    hold_st  = e.st;
                    hold_par = e.par;
                    txn++;
                    $display("txn %0d: state_out low lane %h", txn, state_out[63:0]);
                end else if (!pushout) begin
                    check("hold_state", state_out, hold_st);
`ifdef SHA3_THETA_PARITY_EN
                    check("hold_parity", {1280'b0, col_parity}, {1280'b0, hold_par});
`endif
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t          e;
        logic [1599:0] s;
        total    = 0;
        bad      = 0;
        txn      = 0;
        hold_st  = '0;
        hold_par = '0;
        reset    = 1'b0;
        pushin   = 1'b0;
        state_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", state_out, '0);
        check("reset_pushout", {1599'b0, pushout}, '0);
        reset = 1'b1;
        idle_cycle();

        // 1) all-zero state
        e.st = '0; e.par = '0;
        drive_cycle(1'b1, '0, e);
        idle_cycle();

        // 2) single bit A[0][0]=1: spreads to column 1 unrotated, column 4 rotated
        s = '0; s[0] = 1'b1;
        e.st = '0; e.par = '0; e.par[0] = 1'b1;
        e.st[63:0] = 64'h1;
        for (int y = 0; y < 5; y++) begin
            e.st[64*(5*y+1) +: 64] = 64'h1;
            e.st[64*(5*y+4) +: 64] = 64'h2;
        end
        drive_cycle(1'b1, s, e);

        // 3) rotation wrap of bit 63
        s = '0; s[63] = 1'b1;
        e.st = '0; e.par = '0; e.par[63] = 1'b1;
        e.st[63:0] = 64'h8000000000000000;
        for (int y = 0; y < 5; y++) begin
            e.st[64*(5*y+1) +: 64] = 64'h8000000000000000;
            e.st[64*(5*y+4) +: 64] = 64'h1;
        end
        drive_cycle(1'b1, s, e);

        // 4) all ones: D is zero, state passes through
        e.st = '1; e.par = '1;
        drive_cycle(1'b1, '1, e);
        idle_cycle();

        // Random states, back-to-back and with random gaps
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            else push_model(rand_state());
        end
        idle_cycle();

        // 5) isolated pulses; output must hold between them
        push_model(rand_state());
        idle_cycle();
        idle_cycle();
        push_model(rand_state());
        idle_cycle();
        idle_cycle();

        // 6) asynchronous reset mid-stream while pushout is high
        push_model(rand_state());
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_state", state_out, '0);
        check("async_rst_pushout", {1599'b0, pushout}, '0);
        exp_q.delete();
        hold_st  = '0;
        hold_par = '0;
        pushin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) idle_cycle();
        check("post_rst_state", state_out, '0);
        push_model(rand_state());
        push_model(rand_state());
        idle_cycle();
        idle_cycle();

        check("queue_empty", {1568'b0, 32'(exp_q.size())}, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
